uart_tx_fifo_drain: RTL and testbench

//   Read-side consumer of the async FIFO; lives entirely in the FIFO read-clock domain.

---
 rtl/uart_tx_fifo_drain_pkg.sv | 29 ++
 rtl/uart_tx_fifo_drain_if.sv | 18 +
 rtl/uart_tx_bit_timer.sv | 37 +++
 rtl/uart_tx_fifo_drain.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain_pkg
//   Shared definitions for the UART transmit FIFO drain (the uart_tx_defs set):
//   FSM state encodings, parity type codes, bit-timer width and a parity helper.
//   No ports.
// ---------------------------------------------------------------------------
package uart_tx_fifo_drain_pkg;

  // Largest supported CLKS_PER_BIT; the bit timer is sized from it.
  localparam int CPB_MAX = 64;
  localparam int TIMER_W = $clog2(CPB_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit for a word zero-extended to 64 bits: even -> ^data, odd -> ~^data.
  function automatic logic parity_of(input logic [63:0] data, input logic typ);
    return (^data) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain_if
//   Read-side FIFO handshake between an async FIFO and its consumer.
//   fifo_empty  : FIFO rempty
//   fifo_rdata  : FIFO rdata, valid whenever fifo_empty is low
//   fifo_rinc   : pop strobe from the consumer
//   master modport = consumer (drain), slave modport = FIFO.
// ---------------------------------------------------------------------------
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rinc;

  modport master (input fifo_empty, input fifo_rdata, output fifo_rinc);
  modport slave  (output fifo_empty, output fifo_rdata, input fifo_rinc);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_tx_bit_timer
//   Down-counter that marks the last clock of every serial bit.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : restart the bit period (driven by the FIFO pop strobe)
//   bit_done  : high on the terminal count of the current bit period
// ---------------------------------------------------------------------------
module uart_tx_bit_timer
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] ZERO   = {TIMER_W{1'b0}};

  logic [TIMER_W-1:0] cnt_r;

  // Period counter: reload on pop or on wrap, otherwise count down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= ZERO;
    end else if (clear || (cnt_r == ZERO)) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - TIMER_W'(1);
    end
  end

  assign bit_done = (cnt_r == ZERO);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain
//   Pops words from an async FIFO (read-clock domain) and sends each as a UART
//   frame: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
//   Frames run back to back while the FIFO stays non-empty.
//   Optional feature macro: UART_TX_PARITY_EN (adds par_en/par_typ and PARITY).
//   clk, rst : read clock, asynchronous active-low reset
//   fifo     : FIFO read handshake (master modport), fifo_rinc is combinational
//   par_en   : parity enable (macro only), sampled at each pop
//   par_typ  : 0 even, 1 odd (macro only), sampled at each pop
//   tx_out   : serial line, idle high, registered
//   busy     : high while a frame is on the line, registered
// ---------------------------------------------------------------------------
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_fifo_drain_if.master fifo,
`ifdef UART_TX_PARITY_EN
  input  logic                 par_en,
  input  logic                 par_typ,
`endif
  output logic                 tx_out,
  output logic                 busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_r, state_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic                  tx_r, tx_s;
  logic                  busy_r;
  logic                  bit_done_s;
  logic                  pop_s;

  uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pop_s),
    .bit_done (bit_done_s)
  );

  // Pop when idle or at the very end of a stop bit; never during reset.
  assign pop_s = ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_done_s))
                 && !fifo.fifo_empty && rst;
  assign fifo.fifo_rinc = pop_s;

`ifdef UART_TX_PARITY_EN
  logic par_en_r;
  logic par_bit_r;

  // Parity settings are frozen per frame at the pop edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
    end else if (pop_s) begin
      par_en_r  <= par_en;
      par_bit_r <= parity_of(64'(fifo.fifo_rdata), par_typ);
    end else begin
      par_en_r  <= par_en_r;
      par_bit_r <= par_bit_r;
    end
  end
`endif

  // Next state plus the next line level, so tx_out is a plain flop.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    tx_s    = tx_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_s = ST_START;
          shift_s = fifo.fifo_rdata;
          idx_s   = {IDX_W{1'b0}};
          tx_s    = 1'b0;
        end else begin
          tx_s    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_s = ST_DATA;
          tx_s    = shift_r[0];
        end else begin
          tx_s    = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          if (idx_r == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_r) begin
              state_s = ST_PARITY;
              tx_s    = par_bit_r;
            end else begin
              state_s = ST_STOP;
              tx_s    = 1'b1;
            end
`else
            state_s = ST_STOP;
            tx_s    = 1'b1;
`endif
          end else begin
            shift_s = shift_r >> 1;
            idx_s   = idx_r + IDX_W'(1);
            tx_s    = shift_s[0];
          end
        end else begin
          tx_s = shift_r[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          state_s = ST_STOP;
          tx_s    = 1'b1;
        end else begin
          tx_s    = par_bit_r;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s && pop_s) begin
          state_s = ST_START;
          shift_s = fifo.fifo_rdata;
          idx_s   = {IDX_W{1'b0}};
          tx_s    = 1'b0;
        end else if (bit_done_s) begin
          state_s = ST_IDLE;
          tx_s    = 1'b1;
        end else begin
          tx_s    = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        tx_s    = 1'b1;
      end
    endcase
  end

  // FSM, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      shift_r <= {DATA_WIDTH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign tx_out = tx_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//   Directed bench for uart_tx_fifo_drain. dut1 runs at CLKS_PER_BIT=1 and
//   dut4 at CLKS_PER_BIT=4, each fed by a small queue-based FIFO model.
//   Parity vectors are included when UART_TX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst4;
  logic tx1, busy1, tx4, busy4;
`ifdef UART_TX_PARITY_EN
  logic par_en, par_typ;
`endif

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) if1 ();
  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) if4 ();

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk     (clk),
    .rst     (rst1),
    .fifo    (if1.master),
`ifdef UART_TX_PARITY_EN
    .par_en  (par_en),
    .par_typ (par_typ),
`endif
    .tx_out  (tx1),
    .busy    (busy1)
  );

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk     (clk),
    .rst     (rst4),
    .fifo    (if4.master),
`ifdef UART_TX_PARITY_EN
    .par_en  (par_en),
    .par_typ (par_typ),
`endif
    .tx_out  (tx4),
    .busy    (busy4)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;

  // FIFO models: the pop seen before a rising edge is retired at the next falling edge.
  logic [7:0] q1[$];
  logic [7:0] q4[$];
  int pop_cyc1[$];
  int pops1 = 0, pops4 = 0, under1 = 0, under4 = 0, rincrst = 0;
  logic pend1 = 1'b0, pend4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pend1) begin
      if (q1.size() == 0) under1++;
      else void'(q1.pop_front());
      pops1++;
      pop_cyc1.push_back(cyc);
    end
    if1.fifo_empty = (q1.size() == 0);
    if1.fifo_rdata = (q1.size() == 0) ? 8'h00 : q1[0];
    #1;
    pend1 = if1.fifo_rinc;
    if (if1.fifo_rinc && !rst1) rincrst++;
  end

  always @(negedge clk) begin
    if (pend4) begin
      if (q4.size() == 0) under4++;
      else void'(q4.pop_front());
      pops4++;
    end
    if4.fifo_empty = (q4.size() == 0);
    if4.fifo_rdata = (q4.size() == 0) ? 8'h00 : q4[0];
    #1;
    pend4 = if4.fifo_rinc;
    if (if4.fifo_rinc && !rst4) rincrst++;
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call right after queuing one word: checks the idle cycle with the pop
  // strobe up, every line cycle of the frame, then the return to idle.
  task automatic run_frame(input bit s4, input int cpb, input logic [15:0] bits,
                           input int nbits, input string tag);
    step();
    check({tag, "_rinc"}, {31'd0, s4 ? if4.fifo_rinc : if1.fifo_rinc}, 32'd1);
    check({tag, "_pre_busy"}, {31'd0, s4 ? busy4 : busy1}, 32'd0);
    for (int i = 0; i < nbits * cpb; i++) begin
      step();
      check({tag, "_tx"}, {31'd0, s4 ? tx4 : tx1}, {31'd0, bits[i / cpb]});
      check({tag, "_busy"}, {31'd0, s4 ? busy4 : busy1}, 32'd1);
    end
    step();
    check({tag, "_end_tx"}, {31'd0, s4 ? tx4 : tx1}, 32'd1);
    check({tag, "_end_busy"}, {31'd0, s4 ? busy4 : busy1}, 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int rises;
    logic prev_busy;
    int base;

    rst1 = 1'b0;
    rst4 = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en  = 1'b0;
    par_typ = 1'b0;
`endif

    // 1: reset, then an empty FIFO for 20 cycles.
    step();
    check("rst_tx1", {31'd0, tx1}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_tx4", {31'd0, tx4}, 32'd1);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    step();
    rst1 = 1'b1;
    rst4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_tx1", {31'd0, tx1}, 32'd1);
      check("idle_busy1", {31'd0, busy1}, 32'd0);
      check("idle_rinc1", {31'd0, if1.fifo_rinc}, 32'd0);
      check("idle_rinc4", {31'd0, if4.fifo_rinc}, 32'd0);
    end
    check("idle_pops", pops1 + pops4, 32'd0);

    // 2: single word 0xA5, one bit per clock: 0,1,0,1,0,0,1,0,1,1.
    q1.push_back(8'hA5);
    run_frame(1'b0, 1, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, "a5");
    check("a5_pops", pops1, 32'd1);

`ifdef UART_TX_PARITY_EN
    // 3: word 0x03 has even weight, so even parity 0, odd parity 1.
    par_en  = 1'b1;
    par_typ = 1'b0;
    q1.push_back(8'h03);
    run_frame(1'b0, 1, {5'd0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, "par_even");
    par_typ = 1'b1;
    q1.push_back(8'h03);
    run_frame(1'b0, 1, {5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, "par_odd");
    par_en  = 1'b0;
    q1.push_back(8'h03);
    run_frame(1'b0, 1, {6'd0, 1'b1, 8'h03, 1'b0}, 10, "par_off");
`endif

    // 4: three queued words go out back to back.
    base = pops1;
    pop_cyc1.delete();
    q1.push_back(8'h11);
    q1.push_back(8'h22);
    q1.push_back(8'h33);
    busy_cnt  = 0;
    rises     = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy1) busy_cnt++;
      if (busy1 && !prev_busy) rises++;
      prev_busy = busy1;
    end
    check("b2b_pops", pops1 - base, 32'd3);
    check("b2b_busy_cycles", busy_cnt, 32'd30);
    check("b2b_busy_rises", rises, 32'd1);
    if (pop_cyc1.size() == 3) begin
      check("b2b_gap1", pop_cyc1[1] - pop_cyc1[0], 32'd10);
      check("b2b_gap2", pop_cyc1[2] - pop_cyc1[1], 32'd10);
    end else begin
      check("b2b_pop_count", pop_cyc1.size(), 32'd3);
    end
    check("b2b_no_underflow", under1, 32'd0);

    // 5: reset during data bit 4 of 0xFF.
    base = pops1;
    q1.push_back(8'hFF);
    step();
    step();
    check("rst_mid_start", {31'd0, tx1}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("rst_mid_bit4", {31'd0, tx1}, 32'd1);
    check("rst_mid_busy_pre", {31'd0, busy1}, 32'd1);
    rst1 = 1'b0;
    #1;
    check("rst_mid_tx", {31'd0, tx1}, 32'd1);
    check("rst_mid_busy", {31'd0, busy1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_rinc", {31'd0, if1.fifo_rinc}, 32'd0);
    end
    rst1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_busy", {31'd0, busy1}, 32'd0);
      check("post_rst_tx", {31'd0, tx1}, 32'd1);
    end
    check("post_rst_pops", pops1 - base, 32'd1);
    q1.push_back(8'h5A);
    run_frame(1'b0, 1, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, "after_rst");
    check("after_rst_pops", pops1 - base, 32'd2);

    // 6: four clocks per bit, word 0x00: 36 low cycles then 4 high.
    q4.push_back(8'h00);
    run_frame(1'b1, 4, {6'd0, 1'b1, 8'h00, 1'b0}, 10, "cpb4");
    check("cpb4_pops", pops4, 32'd1);
    check("cpb4_no_underflow", under4, 32'd0);
    check("no_rinc_in_reset", rincrst, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
